// File: rtl/acc_arb_pkg.sv
// Shared types and sizing helpers for the accelerator memory arbiter.
// Run-control state encoding and the channel-id width rule live here.
package acc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_t;

  localparam int unsigned N_CH_DEFAULT = 2;

  // Channel-id width never drops below one bit, even for a single channel
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned CH_ID_W = (N_CH_DEFAULT > 1) ? $clog2(N_CH_DEFAULT) : 1;

endpackage

// File: rtl/acc_mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after
// the priority pointer, with the pointer advancing past each winner.
module rr_arbiter
  import acc_arb_pkg::*;
#(
  parameter int unsigned N_CH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           req_i,
  output logic [N_CH-1:0]           gnt_o,
  output logic [id_width(N_CH)-1:0] gnt_id_o
);

  localparam int unsigned IDW = id_width(N_CH);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           found;
  int unsigned    idx;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = 0;
    // Grant is forced low during reset so nothing reaches memory mid-reset
    if (!rst) begin
      for (int unsigned off = 0; off < N_CH; off++) begin
        idx = 32'(ptr_q) + off;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!found && req_i[idx]) begin
          found       = 1'b1;
          gnt_o[idx]  = 1'b1;
          gnt_id_o    = IDW'(idx);
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      if (32'(gnt_id_o) == N_CH - 1) ptr_d = '0;
      else                           ptr_d = gnt_id_o + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/acc_mem_arbiter.sv
// Shares memory port a between N_CH accelerator channels: round-robin request
// muxing, latency-matched read-data tagging, and start/finish run control.
module acc_mem_arbiter
  import acc_arb_pkg::*;
#(
  parameter int unsigned N_CH         = 2,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [N_CH-1:0]          ch_mask,
  output logic                     finish,
  output logic [N_CH-1:0]          ch_start,
  input  logic [N_CH-1:0]          ch_finish,
  input  logic [N_CH-1:0]          ch_en,
  input  logic [N_CH-1:0]          ch_we,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr,
  input  logic [N_CH*DATA_W-1:0]   ch_dw,
  output logic [N_CH-1:0]          ch_gnt,
  output logic [DATA_W-1:0]        ch_dr,
  output logic [N_CH-1:0]          ch_rvalid,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_dw,
  input  logic [DATA_W-1:0]        mem_dr
);

  localparam int unsigned IDW = id_width(N_CH);

  logic [IDW-1:0] gnt_id;

  rr_arbiter #(.N_CH(N_CH)) u_rr (
    .clk      (clk),
    .rst      (reset),
    .req_i    (ch_en),
    .gnt_o    (ch_gnt),
    .gnt_id_o (gnt_id)
  );

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_dw   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ch_gnt[i]) begin
        mem_we   = ch_we[i];
        mem_addr = ch_addr[i*ADDR_W +: ADDR_W];
        mem_dw   = ch_dw[i*DATA_W +: DATA_W];
      end
    end
  end

  assign mem_en = |ch_gnt;

  // Read tags travel alongside the memory latency; writes push an empty slot
  logic           rd_vld_q [READ_LATENCY];
  logic [IDW-1:0] rd_id_q  [READ_LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        rd_vld_q[i] <= 1'b0;
        rd_id_q[i]  <= '0;
      end
    end else begin
      rd_vld_q[0] <= mem_en && !mem_we;
      rd_id_q[0]  <= gnt_id;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_id_q[i]  <= rd_id_q[i-1];
      end
    end
  end

  always_comb begin
    ch_rvalid = '0;
    if (rd_vld_q[READ_LATENCY-1]) ch_rvalid[rd_id_q[READ_LATENCY-1]] = 1'b1;
  end

  assign ch_dr = mem_dr;

  run_state_t      state_q, state_d;
  logic            start_q;
  logic [N_CH-1:0] mask_q, mask_d;
  logic [N_CH-1:0] sticky_q, sticky_d;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    sticky_d = sticky_q;
    case (state_q)
      IDLE: begin
        if (start && !start_q) begin
          mask_d   = ch_mask;
          sticky_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        sticky_d = sticky_q | (ch_finish & mask_q);
        if ((sticky_q & mask_q) == mask_q) state_d = DONE;
      end
      DONE: begin
        if (!start) begin
          state_d  = IDLE;
          sticky_d = '0;
          mask_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      mask_q   <= '0;
      sticky_q <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      mask_q   <= mask_d;
      sticky_q <= sticky_d;
    end
  end

  assign finish   = (state_q == DONE);
  assign ch_start = (state_q != IDLE) ? mask_q : '0;

endmodule
